// File: rtl/avl_mtimer_pkg.sv
// Shared constants for the Avalon-MM mtime/mtimecmp timer: register map,
// CTRL bit positions, Avalon response codes and a byte-lane merge helper.
package avl_mtimer_pkg;

    localparam int unsigned ADDR_CTRL   = 0;
    localparam int unsigned ADDR_DIV    = 1;
    localparam int unsigned ADDR_MTLO   = 2;
    localparam int unsigned ADDR_MTHI   = 3;
    localparam int unsigned ADDR_CMPLO  = 4;
    localparam int unsigned ADDR_CMPHI  = 5;
    localparam int unsigned ADDR_SNAP   = 6;

    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_IRQ_EN = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/avl_mtimer_presc.sv
// Prescaler: counts 0..div while enabled and emits a one-cycle tick on the
// wrap, so the tick period is div+1 clocks. Disabled holds the count at 0.
module avl_mtimer_presc #(
    parameter int DIV_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (!en) begin
            count_d = '0;
        end else if (count_q == div) begin
            count_d = '0;
            tick    = 1'b1;
        end else begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

endmodule

// File: rtl/avl_mtimer.sv
// Avalon-MM slave exposing a 64-bit mtime/mtimecmp pair with prescaler,
// a registered level interrupt and a HI snapshot for coherent 64-bit reads.
module avl_mtimer
    import avl_mtimer_pkg::*;
#(
    parameter int DIV_W  = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [3:0]        avs_byteenable,
    input  logic [31:0]       avs_writedata,
    output logic              avs_waitrequest,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic [1:0]        avs_response,
    output logic              irq
);

    logic [1:0]       ctrl_q, ctrl_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [63:0]      mtime_q, mtime_d;
    logic [63:0]      mtimecmp_q, mtimecmp_d;
    logic [31:0]      snap_q, snap_d;
    logic             irq_q, irq_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       resp_q, resp_d;
    logic             tick;

    avl_mtimer_presc #(.DIV_W(DIV_W)) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (ctrl_q[CTRL_EN]),
        .div  (div_q),
        .tick (tick)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        div_d      = div_q;
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        snap_d     = snap_q;
        rvalid_d   = avs_read;
        rdata_d    = '0;
        resp_d     = RESP_OKAY;

        // Read path samples pre-write state so read+write in one cycle returns old data.
        if (avs_read) begin
            case (avs_address)
                ADDR_W'(ADDR_CTRL):  rdata_d = {30'b0, ctrl_q};
                ADDR_W'(ADDR_DIV):   rdata_d = 32'(div_q);
                ADDR_W'(ADDR_MTLO): begin
                    rdata_d = mtime_q[31:0];
                    snap_d  = mtime_q[63:32];
                end
                ADDR_W'(ADDR_MTHI):  rdata_d = mtime_q[63:32];
                ADDR_W'(ADDR_CMPLO): rdata_d = mtimecmp_q[31:0];
                ADDR_W'(ADDR_CMPHI): rdata_d = mtimecmp_q[63:32];
                ADDR_W'(ADDR_SNAP):  rdata_d = snap_q;
                default:             resp_d  = RESP_SLVERR;
            endcase
        end

        // A write to either mtime half suppresses that cycle's tick, carry included.
        if (tick) mtime_d = mtime_q + 64'd1;

        if (avs_write) begin
            case (avs_address)
                ADDR_W'(ADDR_CTRL): begin
                    if (avs_byteenable[0]) ctrl_d = avs_writedata[1:0];
                end
                ADDR_W'(ADDR_DIV): begin
                    for (int i = 0; i < DIV_W; i++) begin
                        if (avs_byteenable[i/8]) div_d[i] = avs_writedata[i];
                    end
                end
                ADDR_W'(ADDR_MTLO):
                    mtime_d = {mtime_q[63:32],
                               apply_be(mtime_q[31:0], avs_writedata, avs_byteenable)};
                ADDR_W'(ADDR_MTHI):
                    mtime_d = {apply_be(mtime_q[63:32], avs_writedata, avs_byteenable),
                               mtime_q[31:0]};
                ADDR_W'(ADDR_CMPLO):
                    mtimecmp_d[31:0] = apply_be(mtimecmp_q[31:0], avs_writedata, avs_byteenable);
                ADDR_W'(ADDR_CMPHI):
                    mtimecmp_d[63:32] = apply_be(mtimecmp_q[63:32], avs_writedata, avs_byteenable);
                default: ;
            endcase
        end

        irq_d = ctrl_d[CTRL_IRQ_EN] && (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            div_q      <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RST;
            snap_q     <= '0;
            irq_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= RESP_OKAY;
        end else begin
            ctrl_q     <= ctrl_d;
            div_q      <= div_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            snap_q     <= snap_d;
            irq_q      <= irq_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

    assign avs_waitrequest   = 1'b0;
    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign avs_response      = resp_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_avl_mtimer.sv
// Self-checking bench for avl_mtimer: directed scenarios plus a randomized run,
// all compared against a register-level behavioural model of the timer.
module tb_avl_mtimer;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  avs_address;
    logic        avs_read, avs_write;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_writedata;
    logic        avs_waitrequest;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    logic [1:0]  avs_response;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    avl_mtimer #(.DIV_W(10), .ADDR_W(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_byteenable    (avs_byteenable),
        .avs_writedata     (avs_writedata),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .avs_response      (avs_response),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [1:0]  m_ctrl;
    logic [9:0]  m_div;
    logic [9:0]  m_cnt;
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_snap;
    logic        m_irq;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_ctrl = 0; m_div = 0; m_cnt = 0; m_mtime = 0;
        m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_snap = 0; m_irq = 0;
        exp_rvalid = 0; exp_rdata = 0; exp_resp = 0;
    endtask

    task automatic model_edge(input logic rd, input logic wr, input logic [2:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
        logic tick;
        logic [31:0] rv;
        exp_rvalid = rd;
        exp_rdata  = 0;
        exp_resp   = 0;
        if (rd) begin
            case (a)
                3'd0: rv = {30'b0, m_ctrl};
                3'd1: rv = {22'b0, m_div};
                3'd2: rv = m_mtime[31:0];
                3'd3: rv = m_mtime[63:32];
                3'd4: rv = m_cmp[31:0];
                3'd5: rv = m_cmp[63:32];
                3'd6: rv = m_snap;
                default: rv = 0;
            endcase
            exp_rdata = rv;
            if (a == 3'd7) exp_resp = 2'b10;
            if (a == 3'd2) m_snap = m_mtime[63:32];
        end
        tick = m_ctrl[0] && (m_cnt == m_div);
        if (!m_ctrl[0] || tick) m_cnt = 0;
        else                    m_cnt = m_cnt + 10'd1;
        if (wr) begin
            case (a)
                3'd0: if (be[0]) m_ctrl = wd[1:0];
                3'd1: begin
                    if (be[0]) m_div[7:0] = wd[7:0];
                    if (be[1]) m_div[9:8] = wd[9:8];
                end
                3'd2: m_mtime[31:0]  = merge(m_mtime[31:0], wd, be);
                3'd3: m_mtime[63:32] = merge(m_mtime[63:32], wd, be);
                3'd4: m_cmp[31:0]    = merge(m_cmp[31:0], wd, be);
                3'd5: m_cmp[63:32]   = merge(m_cmp[63:32], wd, be);
                default: ;
            endcase
        end
        if (tick && !(wr && (a == 3'd2 || a == 3'd3))) m_mtime = m_mtime + 64'd1;
        m_irq = m_ctrl[1] && (m_mtime >= m_cmp);
    endtask

    // Called at a negedge; returns at the following negedge with outputs settled.
    task automatic do_cycle(input logic rd, input logic wr, input logic [2:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        avs_read = rd; avs_write = wr; avs_address = a;
        avs_byteenable = be; avs_writedata = wd;
        @(posedge clk);
        model_edge(rd, wr, a, be, wd);
        @(negedge clk);
        avs_read = 0; avs_write = 0; avs_address = 0; avs_byteenable = 0; avs_writedata = 0;
    endtask

    task automatic wr_reg(input logic [2:0] a, input logic [31:0] d);
        do_cycle(1'b0, 1'b1, a, 4'hF, d);
    endtask

    task automatic rd_reg(input logic [2:0] a);
        do_cycle(1'b1, 1'b0, a, 4'h0, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 3'd0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        logic [31:0] rst_vals [7];
        rst_vals = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        wr_reg(3'd1, 32'd2);
        wr_reg(3'd4, 32'd0);
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd0, 32'd3);
        idle(5);
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL reset_pre_irq got=%0b exp=1", irq);
        end
        rd_reg(3'd2);
        rst = 1'b1;
        #1;
        checks++;
        if (irq !== 1'b0 || avs_readdatavalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async irq=%0b rvalid=%0b exp=0/0", irq, avs_readdatavalid);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int a = 0; a < 7; a++) begin
            rd_reg(3'(a));
            checks++;
            if (avs_readdatavalid !== 1'b1 || avs_readdata !== rst_vals[a] ||
                avs_response !== 2'b00) begin
                failures++;
                $display("FAIL reset_reg%0d got=%h/%0b exp=%h/1", a, avs_readdata,
                         avs_readdatavalid, rst_vals[a]);
            end
        end
    endtask

    task automatic test_prescaler();
        logic [3:0] divs [2];
        divs = '{4'd3, 4'd0};
        for (int k = 0; k < 2; k++) begin
            wr_reg(3'd0, 32'd0);
            wr_reg(3'd1, 32'(divs[k]));
            wr_reg(3'd2, 32'd0);
            wr_reg(3'd3, 32'd0);
            wr_reg(3'd0, 32'd1);
            idle(40);
            rd_reg(3'd2);
            checks++;
            if (avs_readdata !== ((k == 0) ? 32'd10 : 32'd40) || avs_readdata !== exp_rdata) begin
                failures++;
                $display("FAIL presc_div%0d got=%0d exp=%0d", divs[k], avs_readdata, exp_rdata);
            end
        end
    endtask

    task automatic test_interrupt();
        logic        prev;
        logic [63:0] rise_at;
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd2, 32'd0);
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd4, 32'd20);
        wr_reg(3'd5, 32'd0);
        wr_reg(3'd0, 32'd3);
        prev = irq;
        rise_at = 64'hDEAD;
        for (int i = 0; i < 30; i++) begin
            idle(1);
            checks++;
            if (irq !== m_irq) begin
                failures++; $display("FAIL irq_cycle%0d got=%0b exp=%0b", i, irq, m_irq);
            end
            if (irq && !prev && rise_at == 64'hDEAD) rise_at = m_mtime;
            prev = irq;
        end
        checks++;
        if (rise_at !== 64'd20) begin
            failures++; $display("FAIL irq_rise_mtime got=%0d exp=20", rise_at);
        end
        wr_reg(3'd4, 32'd100);
        checks++;
        if (irq !== 1'b0 || m_irq !== 1'b0) begin
            failures++; $display("FAIL irq_drop got=%0b exp=0", irq);
        end
        wr_reg(3'd4, 32'd5);
        checks++;
        if (irq !== 1'b1) begin
            failures++; $display("FAIL irq_rearm got=%0b exp=1", irq);
        end
        wr_reg(3'd0, 32'd1);
        checks++;
        if (irq !== 1'b0) begin
            failures++; $display("FAIL irq_en_clear got=%0b exp=0", irq);
        end
    endtask

    task automatic test_coherent();
        for (int k = 0; k < 2; k++) begin
            wr_reg(3'd0, 32'd0);
            wr_reg(3'd1, 32'd0);
            wr_reg(3'd2, 32'hFFFF_FFFE);
            wr_reg(3'd3, 32'd0);
            wr_reg(3'd0, 32'd1);
            idle(1 + k);
            rd_reg(3'd2);
            checks++;
            if (avs_readdata !== ((k == 0) ? 32'hFFFF_FFFF : 32'h0)) begin
                failures++; $display("FAIL coh_lo%0d got=%h exp=%h", k, avs_readdata, exp_rdata);
            end
            rd_reg(3'd6);
            checks++;
            if (avs_readdata !== 32'(k) || avs_readdata !== exp_rdata) begin
                failures++; $display("FAIL coh_snap%0d got=%h exp=%0d", k, avs_readdata, k);
            end
        end
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd2, 32'hFFFF_FFFF);
        wr_reg(3'd3, 32'hFFFF_FFFF);
        wr_reg(3'd0, 32'd1);
        idle(1);
        rd_reg(3'd2);
        checks++;
        if (avs_readdata !== 32'h0) begin
            failures++; $display("FAIL wrap_lo got=%h exp=0", avs_readdata);
        end
        rd_reg(3'd3);
        checks++;
        if (avs_readdata !== 32'h0) begin
            failures++; $display("FAIL wrap_hi got=%h exp=0", avs_readdata);
        end
    endtask

    task automatic test_byte_lane();
        wr_reg(3'd0, 32'd0);
        wr_reg(3'd1, 32'd0);
        wr_reg(3'd2, 32'h1234_5677);
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd0, 32'd1);
        idle(1);
        do_cycle(1'b0, 1'b1, 3'd2, 4'b0011, 32'hAABB_CCDD);
        rd_reg(3'd2);
        checks++;
        if (avs_readdata !== 32'h1234_CCDD || avs_readdata !== exp_rdata) begin
            failures++; $display("FAIL byte_lane_lo got=%h exp=1234ccdd", avs_readdata);
        end
        rd_reg(3'd3);
        checks++;
        if (avs_readdata !== 32'h0) begin
            failures++; $display("FAIL byte_lane_hi got=%h exp=0", avs_readdata);
        end
    endtask

    task automatic test_back_to_back();
        wr_reg(3'd0, 32'd0);
        do_cycle(1'b0, 1'b1, 3'd6, 4'hF, 32'h5555_5555);
        rd_reg(3'd7);
        checks++;
        if (avs_readdata !== 32'h0 || avs_response !== 2'b10 || avs_readdatavalid !== 1'b1) begin
            failures++;
            $display("FAIL unmapped got=%h/%b exp=0/10", avs_readdata, avs_response);
        end
        for (int a = 0; a < 7; a++) begin
            rd_reg(3'(a));
            checks++;
            if (avs_readdatavalid !== 1'b1 || avs_readdata !== exp_rdata ||
                avs_response !== 2'b00 || avs_waitrequest !== 1'b0) begin
                failures++;
                $display("FAIL b2b_addr%0d got=%h/%0b/%b exp=%h/1/00", a, avs_readdata,
                         avs_readdatavalid, avs_response, exp_rdata);
            end
        end
        idle(1);
        checks++;
        if (avs_readdatavalid !== 1'b0) begin
            failures++; $display("FAIL rvalid_idle got=%0b exp=0", avs_readdatavalid);
        end
    endtask

    task automatic test_random();
        logic        rd, wr;
        logic [2:0]  a;
        logic [31:0] wd;
        int          bad;
        bad = 0;
        wr_reg(3'd3, 32'd0);
        wr_reg(3'd5, 32'd0);
        for (int i = 0; i < 400; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 2) == 0);
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd1) wd = $urandom_range(0, 3);
            if (a == 3'd3 || a == 3'd5) wd = $urandom_range(0, 1);
            if (a == 3'd0 && $urandom_range(0, 1) == 1) wd[0] = 1'b1;
            do_cycle(rd, wr, a, 4'($urandom), wd);
            checks++;
            if (avs_readdatavalid !== exp_rvalid || irq !== m_irq ||
                (exp_rvalid && (avs_readdata !== exp_rdata || avs_response !== exp_resp))) begin
                failures++;
                if (bad < 10)
                    $display("FAIL rand%0d rv=%0b/%0b rd=%h/%h resp=%b/%b irq=%0b/%0b", i,
                             avs_readdatavalid, exp_rvalid, avs_readdata, exp_rdata,
                             avs_response, exp_resp, irq, m_irq);
                bad++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        avs_read = 0; avs_write = 0; avs_address = 0; avs_byteenable = 0; avs_writedata = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if (irq !== 1'b0 || avs_readdatavalid !== 1'b0 || avs_readdata !== 32'h0 ||
            avs_response !== 2'b00 || avs_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL por_outputs irq=%0b rv=%0b rd=%h resp=%b wr=%0b", irq,
                     avs_readdatavalid, avs_readdata, avs_response, avs_waitrequest);
        end
        test_reset();
        test_prescaler();
        test_interrupt();
        test_coherent();
        test_byte_lane();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
